// File: rtl/bcd_cascade_ctrl.sv
// bcd_cascade_ctrl: command sequencer for a cascade of 74162-style BCD decade counters
// Ports: clk_i/rst_ni clock and async active-low reset; cmd_* host command handshake;
// q_i counter readback; clr_n_o/ld_n_o/ent_o/enp_o/data_o counter control pins;
// busy_o not idle; done_o/err_o one-cycle completion and error pulses.
module bcd_cascade_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [4*DIGITS-1:0] cmd_val_i,
  input  logic [4*DIGITS-1:0] q_i,
  output logic                clr_n_o,
  output logic                ld_n_o,
  output logic                ent_o,
  output logic                enp_o,
  output logic [4*DIGITS-1:0] data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CHECK, COUNT} state_e;
  localparam logic [1:0] OP_CLEAR = 2'd0, OP_LOAD = 2'd1, OP_COUNT = 2'd2, OP_STOP = 2'd3;
  state_e         state_q, state_d;
  logic [W-1:0]   data_q, data_d, exp_q, exp_d, tgt_q, tgt_d;
  logic           clr_n_q, clr_n_d, ld_n_q, ld_n_d, done_q, done_d, err_q, err_d;
  logic           accept, bad_bcd, hit;
  always_comb begin
    bad_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad_bcd = bad_bcd | (cmd_val_i[4*i +: 4] > 4'd9);
  end
  assign cmd_ready_o = (state_q == IDLE) || (state_q == COUNT);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign hit         = (q_i == tgt_q);
  // Count enable is combinational so the counters freeze on the very edge Q reaches the target.
  assign ent_o       = (state_q == COUNT) && !hit;
  assign enp_o       = ent_o;
  assign clr_n_o     = clr_n_q;
  assign ld_n_o      = ld_n_q;
  assign data_o      = data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  always_comb begin
    state_d = state_q;
    clr_n_d = 1'b1;
    ld_n_d  = 1'b1;
    data_d  = data_q;
    exp_d   = exp_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if ((cmd_op_i == OP_LOAD || cmd_op_i == OP_COUNT) && bad_bcd) err_d = 1'b1;
        else if (cmd_op_i == OP_CLEAR) begin
          state_d = CLEAR;
          clr_n_d = 1'b0;
          exp_d   = '0;
        end else if (cmd_op_i == OP_LOAD) begin
          state_d = LOAD;
          ld_n_d  = 1'b0;
          data_d  = cmd_val_i;
          exp_d   = cmd_val_i;
        end else if (cmd_op_i == OP_COUNT) begin
          state_d = COUNT;
          tgt_d   = cmd_val_i;
        end
      end
      CLEAR, LOAD: state_d = CHECK;
      CHECK: begin
        state_d = IDLE;
        done_d  = (q_i == exp_q);
        err_d   = (q_i != exp_q);
      end
      // A target match takes priority over a STOP arriving in the same cycle.
      COUNT: if (hit) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (accept) begin
        if (cmd_op_i == OP_STOP) state_d = IDLE;
        else err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      clr_n_q <= 1'b1;
      ld_n_q  <= 1'b1;
      data_q  <= '0;
      exp_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_n_q <= clr_n_d;
      ld_n_q  <= ld_n_d;
      data_q  <= data_d;
      exp_q   <= exp_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// tb_bcd_cascade_ctrl: directed bench with a behavioural two-digit 74162 cascade
module tb_bcd_cascade_ctrl;
  logic       clk = 1'b0, rst_n = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_val = 8'h00, q, data;
  logic       clr_n, ld_n, ent, enp, busy, done, err;
  logic [7:0] cnt, poke_val = 8'h00, force_val = 8'h00;
  logic       poke = 1'b0, force_en = 1'b0;
  int         total = 0, passed = 0;
  int         n_en, n_done, bad_ctl;
  logic       wrapped;
  always #5 clk = ~clk;
  bcd_cascade_ctrl #(.DIGITS(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_val_i(cmd_val), .q_i(q), .clr_n_o(clr_n), .ld_n_o(ld_n),
    .ent_o(ent), .enp_o(enp), .data_o(data), .busy_o(busy), .done_o(done), .err_o(err)
  );
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    int n;
    n = (int'(v[7:4]) * 10 + int'(v[3:0]) + 1) % 100;
    return {4'(n / 10), 4'(n % 10)};
  endfunction
  always @(posedge clk)
    if (poke) cnt <= poke_val;
    else if (!clr_n) cnt <= 8'h00;
    else if (!ld_n) cnt <= data;
    else if (ent && enp) cnt <= bcd_inc(cnt);
  assign q = force_en ? force_val : cnt;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else passed++;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [7:0] val);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_val = val;
    cyc();
    cmd_valid = 1'b0;
  endtask
  task automatic set_q(input logic [7:0] v);
    poke = 1'b1;
    poke_val = v;
    cyc();
    poke = 1'b0;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    set_q(8'h37);
    check("rst_clr_n", clr_n, 1);
    check("rst_ld_n", ld_n, 1);
    check("rst_data", data, 0);
    check("rst_en", {ent, enp}, 0);
    check("rst_busy_done_err", {busy, done, err}, 0);
    check("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    cyc();
    send(2'd0, 8'h00);
    check("clr_low", clr_n, 0);
    check("clr_busy", busy, 1);
    check("clr_ld_n", ld_n, 1);
    cyc();
    check("clr_release", clr_n, 1);
    check("clr_q", q, 8'h00);
    check("clr_busy2", busy, 1);
    check("clr_done_early", done, 0);
    cyc();
    check("clr_done", {done, err, busy}, 3'b100);
    cyc();
    check("clr_done_pulse", done, 0);
    send(2'd1, 8'h58);
    check("ld_low", ld_n, 0);
    check("ld_data", data, 8'h58);
    cyc();
    check("ld_release", ld_n, 1);
    check("ld_q", q, 8'h58);
    cyc();
    check("ld_done", {done, err}, 2'b10);
    send(2'd1, 8'h58);
    force_en = 1'b1;
    force_val = 8'h57;
    cyc();
    cyc();
    check("ld_bad_err", {done, err}, 2'b01);
    force_en = 1'b0;
    cyc();
    check("ld_err_pulse", err, 0);
    set_q(8'h95);
    send(2'd2, 8'h03);
    n_en = 0;
    n_done = 0;
    bad_ctl = 0;
    wrapped = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (enp) n_en++;
      if (done) n_done++;
      if (q == 8'h00) wrapped = 1'b1;
      if ((enp || ent) && (!clr_n || !ld_n)) bad_ctl++;
      cyc();
    end
    check("cnt_en_cycles", n_en, 8);
    check("cnt_done_count", n_done, 1);
    check("cnt_wrapped", wrapped, 1);
    check("cnt_final_q", q, 8'h03);
    check("cnt_ctl_overlap", bad_ctl, 0);
    set_q(8'h42);
    send(2'd2, 8'h42);
    check("zero_cnt_en", enp, 0);
    check("zero_cnt_busy", busy, 1);
    cyc();
    check("zero_cnt_done", {done, busy}, 2'b10);
    check("zero_cnt_q", q, 8'h42);
    send(2'd1, 8'h4A);
    check("bad_bcd_err", {err, ld_n, busy}, 3'b110);
    check("bad_bcd_data", data, 8'h58);
    cyc();
    check("bad_bcd_err_pulse", {err, busy, done}, 0);
    send(2'd3, 8'h00);
    check("stop_idle_noop", {done, err, busy}, 0);
    set_q(8'h10);
    send(2'd2, 8'h50);
    check("c50_en", {ent, enp}, 2'b11);
    cyc();
    cyc();
    send(2'd1, 8'h33);
    check("c50_load_err", {err, busy, ld_n}, 3'b111);
    check("c50_q13", q, 8'h13);
    cyc();
    cyc();
    check("c50_q15", q, 8'h15);
    send(2'd3, 8'h00);
    check("stop_q", q, 8'h16);
    check("stop_state", {busy, done, enp}, 0);
    cyc();
    check("stop_no_done", {done, q}, {1'b0, 8'h16});
    set_q(8'h05);
    send(2'd2, 8'h07);
    cyc();
    cyc();
    check("tie_q", q, 8'h07);
    send(2'd3, 8'h00);
    check("tie_done", {done, busy}, 2'b10);
    set_q(8'h20);
    send(2'd2, 8'h30);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_drop", {ent, enp, busy}, 0);
    cyc();
    cyc();
    check("mid_rst_q", q, 8'h22);
    rst_n = 1'b1;
    cyc();
    check("post_rst_ready", {cmd_ready, done, err, busy}, 4'b1000);
    check("post_rst_q", q, 8'h22);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd_cascade_ctrl.md
Name: bcd_cascade_ctrl

Overview:
- Command-driven sequencer for a cascade of DIGITS 74162-style synchronous decade counters that share CLK with this block.
- Drives the counters' ~CLR, ~LD, ENT, ENP and parallel data pins, and reads back their Q outputs.
- Provides three operations: clear with readback verify, load a preset with verify, and count up to a BCD target then stop.
- Sits between a host command interface and the counter datapath.

Parameters:
DIGITS, 2, number of cascaded decade stages; bus widths are 4*DIGITS, with digit 0 in bits [3:0].

Ports:
CLK  in  1  single clock, rising edge; the counters use the same clock.
~RST  in  1  asynchronous active-low reset.
CMD_VALID  in  1  host command valid.
CMD_READY  out  1  block accepts a command this cycle.
CMD_OP  in  2  00 CLEAR, 01 LOAD, 10 COUNT_TO, 11 STOP.
CMD_VAL  in  4*DIGITS  BCD preset (LOAD) or target (COUNT_TO).
Q  in  4*DIGITS  counter outputs, BCD.
~CLR  out  1  to counter ~CLR (synchronous clear).
~LD  out  1  to counter ~LD (synchronous load).
ENT  out  1  to stage-0 ENT.
ENP  out  1  to all ENP pins.
DATA  out  4*DIGITS  to counter A..D pins.
BUSY  out  1  state is not IDLE.
DONE  out  1  one-cycle completion pulse.
ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately:
  - state=IDLE, ~CLR=1, ~LD=1, DATA=0, ENT=ENP=0, BUSY=0, DONE=0, ERR=0, target register=0.
  - The counters themselves are not touched by reset.
- States are IDLE, CLEAR, LOAD, CHECK, COUNT.
- Handshake:
  - A command is accepted on a rising edge with CMD_VALID and CMD_READY both high.
  - CMD_READY=1 in IDLE and COUNT, 0 otherwise.
- BCD validation:
  - If any 4-bit digit of CMD_VAL is >9 for LOAD or COUNT_TO, the command is consumed, the state is unchanged, and ERR pulses in the next cycle.
  - CMD_VAL is ignored for CLEAR and STOP.
- IDLE transitions:
  - CLEAR goes to CLEAR; expected value := 0.
  - LOAD goes to LOAD; DATA := CMD_VAL; expected := CMD_VAL.
  - COUNT_TO goes to COUNT; target := CMD_VAL.
  - STOP is a no-op: consumed, with no DONE or ERR.
- CLEAR: ~CLR=0 (registered) for exactly one cycle, then go to CHECK.
- LOAD: ~LD=0 for exactly one cycle with DATA stable, then go to CHECK.
  - DATA holds its value until the next LOAD.
- CHECK (one cycle), with Q reflecting the preceding edge:
  - If Q == expected, DONE pulses the next cycle.
  - Otherwise ERR pulses the next cycle.
  - Either way, go to IDLE.
- COUNT:
  - ENT = ENP = (state==COUNT) && (Q != target). This is combinational from the registered state and Q, so the counters stop exactly on the target.
  - When Q == target, go to IDLE and DONE pulses the next cycle.
  - If the target already equals Q on entry, zero counts occur, followed by one COUNT cycle and then DONE.
  - Wrap through all-9s is permitted; the count wraps modulo 10^DIGITS until it reaches the target.
- STOP in COUNT:
  - Accepted, then go to IDLE with no DONE.
  - The counters still advance on the acceptance edge if ENP was high; ENT/ENP are 0 from the next cycle.
- Any other op in COUNT: consumed, ERR pulses, and counting continues.
- If STOP arrives in the same cycle that Q == target, the target match wins and DONE pulses.
- Outputs are registered except ENT/ENP.
- ~CLR and ~LD are never low simultaneously, and are never low while ENT/ENP are high.
- Reset mid-operation: control lines release asynchronously; no DONE or ERR follows.

Test Plan:
- Reset, then CLEAR with Q at 37 → ~CLR low for one cycle; Q=00 at CHECK; DONE one cycle later; BUSY high for 2 cycles.
- LOAD 0x58 → DATA=0x58, ~LD low for one cycle, Q=58, DONE; repeat with Q forced to 0x57 at CHECK → ERR, no DONE.
- Q=95, COUNT_TO 0x03 → ENP high for exactly 8 cycles; Q passes 99→00 and stops at 03; DONE pulses once.
- COUNT_TO 0x42 with Q=42 → zero ENP cycles, DONE; LOAD with CMD_VAL=0x4A → ERR, no ~LD, stays IDLE.
- COUNT_TO 0x50 from 10, STOP after 5 counts → Q=16 (includes the acceptance edge), no DONE; LOAD issued during COUNT → ERR, count continues.
- ~RST asserted mid-COUNT → ENT/ENP/BUSY drop immediately; Q frozen; after release, CMD_READY=1 in IDLE.
